// File: rtl/bcd_dpd_packer.sv
// ---------------------------------------------------------------------------
// bcd_dpd_packer
//
// Collects up to three BCD digits (most significant first) into a group and
// presents that group as a 10-bit IEEE 754 densely packed decimal declet.
// The same group is also presented as its plain binary value.
// A group closes after its third digit, or earlier when in_last is seen.
// Digits not supplied are zero-filled on the right.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : in_digit is presented
//   in_ready   : block accepts a digit this cycle (NOT out_valid)
//   in_digit   : one BCD digit, most significant first
//   in_last    : accepted digit closes the current group
//   out_valid  : declet is held on the outputs
//   out_ready  : consumer takes the declet
//   out_dpd    : DPD encoding of the group (bit 9 = p ... bit 0 = y)
//   out_bin    : d2*100 + d1*10 + d0
//   out_count  : number of real digits in the group (1..3)
//   out_last   : group was closed by in_last
//   out_err    : at least one digit of the group was >= 10
// ---------------------------------------------------------------------------
module bcd_dpd_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_digit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_dpd,
    output logic [9:0] out_bin,
    output logic [1:0] out_count,
    output logic       out_last,
    output logic       out_err
);

    typedef enum logic [1:0] {ACC0, ACC1, ACC2, FULL} state_t;

    state_t     state_q, state_d;
    logic [3:0] d2_q, d2_d;
    logic [3:0] d1_q, d1_d;
    logic       err_q, err_d;
    logic [9:0] dpd_q, dpd_d;
    logic [9:0] bin_q, bin_d;
    logic [1:0] count_q, count_d;
    logic       last_q, last_d;
    logic       gerr_q, gerr_d;

    logic       accept;
    logic       digBad;
    logic [3:0] digClean;
    logic [3:0] g2, g1, g0;
    logic [1:0] gCount;

    // Table-driven DPD encoder. a/e/i flag the "large" digits (8 or 9);
    // for a large digit only its low bit carries information.
    function automatic logic [9:0] dpdEncode(input logic [3:0] h,
                                             input logic [3:0] t,
                                             input logic [3:0] u);
        logic [9:0] r;
        case ({h[3], t[3], u[3]})
            3'b000:  r = {h[2:0], t[2:0], 1'b0, u[2:0]};
            3'b001:  r = {h[2:0], t[2:0], 1'b1, 2'b00, u[0]};
            3'b010:  r = {h[2:0], u[2:1], t[0], 1'b1, 2'b01, u[0]};
            3'b100:  r = {u[2:1], h[0], t[2:0], 1'b1, 2'b10, u[0]};
            3'b110:  r = {u[2:1], h[0], 2'b00, t[0], 1'b1, 2'b11, u[0]};
            3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 1'b1, 2'b11, u[0]};
            3'b011:  r = {h[2:0], 2'b10, t[0], 1'b1, 2'b11, u[0]};
            default: r = {2'b00, h[0], 2'b11, t[0], 1'b1, 2'b11, u[0]};
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign out_dpd   = dpd_q;
    assign out_bin   = bin_q;
    assign out_count = count_q;
    assign out_last  = last_q;
    assign out_err   = gerr_q;

    assign accept   = in_valid && in_ready;
    assign digBad   = (in_digit > 4'd9);
    assign digClean = digBad ? 4'd0 : in_digit;

    // The group as it would look if the digit on the bus closed it now:
    // stored digits first, the incoming digit next, zeros after that.
    always_comb begin
        g2     = d2_q;
        g1     = 4'd0;
        g0     = 4'd0;
        gCount = 2'd3;
        case (state_q)
            ACC0: begin
                g2     = digClean;
                gCount = 2'd1;
            end
            ACC1: begin
                g1     = digClean;
                gCount = 2'd2;
            end
            ACC2: begin
                g1     = d1_q;
                g0     = digClean;
                gCount = 2'd3;
            end
            default: begin
                g2     = d2_q;
            end
        endcase
    end

    // Next-state logic. Output registers are loaded only when a group closes
    // and are cleared again when the consumer takes it, so they read zero
    // everywhere outside FULL.
    always_comb begin
        state_d = state_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        err_d   = err_q;
        dpd_d   = dpd_q;
        bin_d   = bin_q;
        count_d = count_q;
        last_d  = last_q;
        gerr_d  = gerr_q;

        if (state_q == FULL) begin
            if (out_ready) begin
                state_d = ACC0;
                dpd_d   = 10'd0;
                bin_d   = 10'd0;
                count_d = 2'd0;
                last_d  = 1'b0;
                gerr_d  = 1'b0;
            end
        end else if (accept) begin
            if (state_q == ACC2 || in_last) begin
                state_d = FULL;
                dpd_d   = dpdEncode(g2, g1, g0);
                bin_d   = {6'd0, g2} * 10'd100 + {6'd0, g1} * 10'd10 + {6'd0, g0};
                count_d = gCount;
                last_d  = in_last;
                gerr_d  = err_q | digBad;
                d2_d    = 4'd0;
                d1_d    = 4'd0;
                err_d   = 1'b0;
            end else if (state_q == ACC0) begin
                state_d = ACC1;
                d2_d    = digClean;
                err_d   = err_q | digBad;
            end else begin
                state_d = ACC2;
                d1_d    = digClean;
                err_d   = err_q | digBad;
            end
        end
    end

    // State and datapath registers; reset drops any partial or held group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC0;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            err_q   <= 1'b0;
            dpd_q   <= 10'd0;
            bin_q   <= 10'd0;
            count_q <= 2'd0;
            last_q  <= 1'b0;
            gerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            err_q   <= err_d;
            dpd_q   <= dpd_d;
            bin_q   <= bin_d;
            count_q <= count_d;
            last_q  <= last_d;
            gerr_q  <= gerr_d;
        end
    end

endmodule

// File: tb/tb_bcd_dpd_packer.sv
// ---------------------------------------------------------------------------
// tb_bcd_dpd_packer
//
// Directed bench for bcd_dpd_packer. A digit-level model of the packer
// predicts every output on every cycle. Hand-computed literals for
// each directed group pin that model down.
// ---------------------------------------------------------------------------
module tb_bcd_dpd_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_digit = 4'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_dpd;
    logic [9:0] out_bin;
    logic [1:0] out_count;
    logic       out_last;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    bcd_dpd_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dpd   (out_dpd),
        .out_bin   (out_bin),
        .out_count (out_count),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check in the bench funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // DPD from decimal digit values. Each digit contributes its value mod 8
    // as a 3-bit field and its value mod 2 as its low bit; which fields are
    // used where depends on which digits are 8 or 9.
    function automatic int modelDpd(input int h, input int t, input int u);
        int hb, hd, tb, td, tfg, ub, ud, ujk, r;
        hb = h % 8;  hd = h % 2;
        tb = t % 8;  td = t % 2;  tfg = tb / 2;
        ub = u % 8;  ud = u % 2;  ujk = ub / 2;
        case ((h >= 8 ? 4 : 0) + (t >= 8 ? 2 : 0) + (u >= 8 ? 1 : 0))
            0:       r = hb * 128 + tb * 16 + ub;
            1:       r = hb * 128 + tb * 16 + 8 + ud;
            2:       r = hb * 128 + (ujk * 2 + td) * 16 + 10 + ud;
            4:       r = (ujk * 2 + hd) * 128 + tb * 16 + 12 + ud;
            6:       r = (ujk * 2 + hd) * 128 + td * 16 + 14 + ud;
            5:       r = (tfg * 2 + hd) * 128 + (2 + td) * 16 + 14 + ud;
            3:       r = hb * 128 + (4 + td) * 16 + 14 + ud;
            default: r = hd * 128 + (6 + td) * 16 + 14 + ud;
        endcase
        return r;
    endfunction

    // Model state: digits collected so far plus the group on display.
    int mCnt;
    int mDig[3];
    bit mErr;
    bit mFull;
    int expDpd, expBin, expCount;
    bit expLast, expErr;
    bit rstPulsed = 1'b0;

    always @(posedge rst) rstPulsed = 1'b1;

    // Compare, then advance the model with the inputs the DUT will see at
    // the next rising edge.
    always @(negedge clk) begin
        if (rst || rstPulsed) begin
            mCnt = 0; mErr = 0; mFull = 0;
            expDpd = 0; expBin = 0; expCount = 0; expLast = 0; expErr = 0;
            rstPulsed = 1'b0;
        end

        checkOutput("cyc_out_valid", out_valid, mFull);
        checkOutput("cyc_in_ready", in_ready, !mFull);
        checkOutput("cyc_out_dpd", out_dpd, mFull ? expDpd : 0);
        checkOutput("cyc_out_bin", out_bin, mFull ? expBin : 0);
        checkOutput("cyc_out_count", out_count, mFull ? expCount : 0);
        checkOutput("cyc_out_last", out_last, mFull ? expLast : 0);
        checkOutput("cyc_out_err", out_err, mFull ? expErr : 0);

        if (!rst) begin
            if (mFull) begin
                if (out_ready) mFull = 0;
            end else if (in_valid) begin
                int d;
                d = int'(in_digit);
                if (d >= 10) begin
                    mErr = 1;
                    d = 0;
                end
                mDig[mCnt] = d;
                mCnt++;
                if (mCnt == 3 || in_last) begin
                    for (int k = mCnt; k < 3; k++) mDig[k] = 0;
                    expDpd   = modelDpd(mDig[0], mDig[1], mDig[2]);
                    expBin   = mDig[0] * 100 + mDig[1] * 10 + mDig[2];
                    expCount = mCnt;
                    expLast  = in_last;
                    expErr   = mErr;
                    mFull    = 1;
                    mCnt     = 0;
                    mErr     = 0;
                end
            end
        end
    end

    // Present one digit and hold it until it is accepted (bounded).
    task automatic applyStimulus(input logic [3:0] d, input logic last);
        bit ok;
        ok = 0;
        in_digit = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                @(posedge clk); #2;
                ok = 1;
                break;
            end
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("accept_timeout", ok, 1);
    endtask

    task automatic waitValid(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                ok = 1;
                break;
            end
            @(posedge clk); #2;
        end
        checkOutput({name, "_valid"}, ok, 1);
    endtask

    task automatic checkGroup(input string name, input int dpd, input int bin,
                              input int cnt, input bit last, input bit err);
        waitValid(name);
        checkOutput({name, "_dpd"}, out_dpd, dpd);
        checkOutput({name, "_bin"}, out_bin, bin);
        checkOutput({name, "_count"}, out_count, cnt);
        checkOutput({name, "_last"}, out_last, last);
        checkOutput({name, "_err"}, out_err, err);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_dpd", out_dpd, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // 1,2,3 with the consumer always ready
        out_ready = 1'b1;
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd2, 1'b0);
        applyStimulus(4'd3, 1'b0);
        checkGroup("g123", 'h0A3, 'h07B, 3, 0, 0);
        @(posedge clk); #2;
        checkOutput("g123_taken", out_valid, 0);

        // 9,9,9 held by back-pressure for five cycles
        out_ready = 1'b0;
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b0);
        checkGroup("g999", 'h0FF, 'h3E7, 3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            checkOutput("g999_hold_dpd", out_dpd, 'h0FF);
            checkOutput("g999_hold_bin", out_bin, 'h3E7);
            checkOutput("g999_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        checkOutput("g999_release_in_ready", in_ready, 1);

        // partial group closed by in_last
        applyStimulus(4'd4, 1'b0);
        applyStimulus(4'd5, 1'b1);
        checkGroup("g45", 'h250, 450, 2, 1, 0);

        // invalid leading digit is zeroed and flagged
        applyStimulus(4'hC, 1'b0);
        applyStimulus(4'd3, 1'b0);
        applyStimulus(4'd4, 1'b0);
        checkGroup("gC34", 'h034, 34, 3, 0, 1);

        // reset pulse between edges discards the partial group
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd2, 1'b0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        checkOutput("rstpulse_out_valid", out_valid, 0);
        applyStimulus(4'd7, 1'b0);
        applyStimulus(4'd8, 1'b0);
        applyStimulus(4'd9, 1'b0);
        checkGroup("g789", 'h3CF, 789, 3, 0, 0);

        // digits on the bus without in_valid are ignored
        @(posedge clk); #2;
        in_digit = 4'd9;
        in_last  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            checkOutput("idle_out_valid", out_valid, 0);
        end
        in_last = 1'b0;

        // large leading digit, then a lone invalid digit closed by in_last
        applyStimulus(4'd8, 1'b0);
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd1, 1'b0);
        checkGroup("g801", 'h00D, 801, 3, 0, 0);
        applyStimulus(4'hF, 1'b1);
        checkGroup("gF", 0, 0, 1, 1, 1);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
